// File: rtl/cpu_sequencer.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/(MEM)/WB, 4 cycles (5 with MEM) at zero wait.
// Backpressure: FETCH holds imem_req until imem_ready, MEM holds dmem_req/dmem_we until dmem_ready.
module cpu_sequencer #(
  parameter int         CNT_W     = 32,
  parameter logic [2:0] NOTLOAD   = 3'd0,
  parameter logic [1:0] NOTSTORE  = 2'd0,
  parameter logic [2:0] NOTBRANCH = 3'd0,
  parameter logic [2:0] BJAL      = 3'd1,
  parameter logic [2:0] BJALR     = 3'd2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             halt_req,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             ir_we,
  input  logic [2:0]       info_load,
  input  logic [1:0]       info_store,
  input  logic [2:0]       info_branch,
  input  logic             write_reg,
  input  logic             br_taken,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             pc_we,
  output logic             pc_sel,
  output logic [2:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  logic [2:0] state_q;
  logic [2:0] state_d;

  logic is_load;
  logic is_store;
  logic is_jump;
  logic is_cond;
  logic active;

  assign is_load  = (info_load != NOTLOAD);
  assign is_store = (info_store != NOTSTORE);
  assign is_jump  = (info_branch == BJAL) || (info_branch == BJALR);
  assign is_cond  = (info_branch != NOTBRANCH) && !is_jump;
  assign active   = (state_q >= S_FETCH) && (state_q <= S_WB);

  assign state  = state_q;
  assign halted = (state_q == S_HALT);

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:   state_d = run ? S_FETCH : S_IDLE;
      S_FETCH:  state_d = imem_ready ? S_DECODE : S_FETCH;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = (is_load || is_store) ? S_MEM : S_WB;
      S_MEM:    state_d = dmem_ready ? S_WB : S_MEM;
      // halt_req outranks run so a stop request is never lost to back-to-back execution
      S_WB:     state_d = halt_req ? S_HALT : (run ? S_FETCH : S_IDLE);
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    reg_we   = 1'b0;
    wb_sel   = WB_ALU;
    pc_we    = 1'b0;
    pc_sel   = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
      end
      S_WB: begin
        pc_we  = 1'b1;
        reg_we = write_reg;
        if (is_load)
          wb_sel = WB_LOAD;
        else if (is_jump)
          wb_sel = WB_PC4;
        pc_sel = is_jump || (is_cond && br_taken);
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (active)
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (state_q == S_WB)
        instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end

  a_mem_excl: assert property (@(posedge clk) disable iff (rst) !(imem_req && dmem_req));
  a_we_scope: assert property (@(posedge clk) disable iff (rst)
                               (ir_we || reg_we || pc_we) |-> (state_q == S_FETCH || state_q == S_WB));

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: per-cycle state/control checks and counter tracking.
module tb_cpu_sequencer;

  localparam logic [2:0] NOTLOAD   = 3'd0;
  localparam logic [2:0] LD_W      = 3'd3;
  localparam logic [1:0] NOTSTORE  = 2'd0;
  localparam logic [1:0] ST_W      = 2'd2;
  localparam logic [2:0] NOTBRANCH = 3'd0;
  localparam logic [2:0] BJAL      = 3'd1;
  localparam logic [2:0] BJALR     = 3'd2;
  localparam logic [2:0] BR_EQ     = 3'd4;

  logic        clk;
  logic        rst;
  logic        run;
  logic        halt_req;
  logic        imem_req;
  logic        imem_ready;
  logic        ir_we;
  logic [2:0]  info_load;
  logic [1:0]  info_store;
  logic [2:0]  info_branch;
  logic        write_reg;
  logic        br_taken;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic        pc_we;
  logic        pc_sel;
  logic [2:0]  state;
  logic        halted;
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;

  logic [9:0]  ctl;
  assign ctl = {imem_req, ir_we, dmem_req, dmem_we, reg_we, wb_sel, pc_we, pc_sel, halted};

  int checks;
  int failures;
  int exp_cyc;
  int exp_ret;

  cpu_sequencer #(
    .CNT_W(32), .NOTLOAD(NOTLOAD), .NOTSTORE(NOTSTORE),
    .NOTBRANCH(NOTBRANCH), .BJAL(BJAL), .BJALR(BJALR)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .halt_req(halt_req),
    .imem_req(imem_req), .imem_ready(imem_ready), .ir_we(ir_we),
    .info_load(info_load), .info_store(info_store), .info_branch(info_branch),
    .write_reg(write_reg), .br_taken(br_taken),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .reg_we(reg_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel),
    .state(state), .halted(halted), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from IDLE; run drops in EXEC and is re-driven to run_wb for the WB exit.
  task automatic do_instr(input string tag, input logic [2:0] ld, input logic [1:0] st,
                          input logic [2:0] br, input logic wr, input logic tk,
                          input int iwait, input logic mem, input int dwait, input logic exp_dwe,
                          input logic [1:0] exp_wb, input logic exp_pcs,
                          input logic hreq, input logic run_wb, input logic [2:0] exp_next);
    int k;
    info_load = ld; info_store = st; info_branch = br;
    write_reg = wr; br_taken = tk;
    run = 1'b1; halt_req = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    #1;
    check({tag, ":idle"}, 32'(state), 32'd0);
    tick();
    k = 0;
    for (int i = 0; i <= iwait; i++) begin
      imem_ready = (i == iwait);
      #1;
      check({tag, ":fetch_st"}, 32'(state), 32'd1);
      check({tag, ":imem_req"}, 32'(imem_req), 32'd1);
      check({tag, ":ir_we"}, 32'(ir_we), 32'(i == iwait));
      check({tag, ":fetch_dreq"}, 32'(dmem_req), 32'd0);
      tick();
      k++;
    end
    imem_ready = 1'b0;
    #1;
    check({tag, ":decode_st"}, 32'(state), 32'd2);
    check({tag, ":decode_ctl"}, 32'(ctl), 32'd0);
    tick();
    k++;
    run = 1'b0;
    #1;
    check({tag, ":exec_st"}, 32'(state), 32'd3);
    check({tag, ":exec_ctl"}, 32'(ctl), 32'd0);
    tick();
    k++;
    if (mem) begin
      for (int j = 0; j <= dwait; j++) begin
        dmem_ready = (j == dwait);
        #1;
        check({tag, ":mem_st"}, 32'(state), 32'd4);
        check({tag, ":dmem_req"}, 32'(dmem_req), 32'd1);
        check({tag, ":dmem_we"}, 32'(dmem_we), 32'(exp_dwe));
        check({tag, ":mem_ireq"}, 32'(imem_req), 32'd0);
        check({tag, ":mem_we"}, 32'({reg_we, pc_we}), 32'd0);
        tick();
        k++;
      end
      dmem_ready = 1'b0;
    end
    halt_req = hreq;
    run = run_wb;
    #1;
    check({tag, ":wb_st"}, 32'(state), 32'd5);
    check({tag, ":pc_we"}, 32'(pc_we), 32'd1);
    check({tag, ":reg_we"}, 32'(reg_we), 32'(wr));
    check({tag, ":wb_sel"}, 32'(wb_sel), 32'(exp_wb));
    check({tag, ":pc_sel"}, 32'(pc_sel), 32'(exp_pcs));
    check({tag, ":wb_reqs"}, 32'({imem_req, dmem_req, ir_we}), 32'd0);
    check({tag, ":wb_cyc"}, cycle_cnt, 32'(exp_cyc + k));
    check({tag, ":wb_ret"}, instret_cnt, 32'(exp_ret));
    tick();
    exp_cyc = exp_cyc + k + 1;
    exp_ret = exp_ret + 1;
    halt_req = 1'b0;
    run = 1'b0;
    #1;
    check({tag, ":next_st"}, 32'(state), 32'(exp_next));
    check({tag, ":cyc"}, cycle_cnt, 32'(exp_cyc));
    check({tag, ":ret"}, instret_cnt, 32'(exp_ret));
  endtask

  initial begin
    checks = 0; failures = 0; exp_cyc = 0; exp_ret = 0;
    rst = 1'b1; run = 1'b1; halt_req = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    info_load = NOTLOAD; info_store = NOTSTORE; info_branch = NOTBRANCH;
    write_reg = 1'b0; br_taken = 1'b0;
    tick();
    tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_ctl", 32'(ctl), 32'd0);
    check("rst_cyc", cycle_cnt, 32'd0);
    check("rst_ret", instret_cnt, 32'd0);
    rst = 1'b0;

    // ADD back-to-back: WB exit with run=1 goes straight to FETCH; cycle=4, instret=1
    do_instr("add", NOTLOAD, NOTSTORE, NOTBRANCH, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0,
             2'd0, 1'b0, 1'b0, 1'b1, 3'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cyc = 0; exp_ret = 0;
    check("rst2_state", 32'(state), 32'd0);
    check("rst2_cyc", cycle_cnt, 32'd0);
    check("rst2_ret", instret_cnt, 32'd0);

    do_instr("lw", LD_W, NOTSTORE, NOTBRANCH, 1'b1, 1'b0, 0, 1'b1, 3, 1'b0,
             2'd1, 1'b0, 1'b0, 1'b0, 3'd0);
    check("lw_total_cyc", cycle_cnt, 32'd8);
    do_instr("sw", NOTLOAD, ST_W, NOTBRANCH, 1'b0, 1'b0, 2, 1'b1, 0, 1'b1,
             2'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    check("sw_total_cyc", cycle_cnt, 32'd15);
    do_instr("beq_t", NOTLOAD, NOTSTORE, BR_EQ, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0,
             2'd0, 1'b1, 1'b0, 1'b0, 3'd0);
    do_instr("beq_nt", NOTLOAD, NOTSTORE, BR_EQ, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0,
             2'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    do_instr("jal", NOTLOAD, NOTSTORE, BJAL, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0,
             2'd2, 1'b1, 1'b0, 1'b0, 3'd0);
    do_instr("jalr", NOTLOAD, NOTSTORE, BJALR, 1'b1, 1'b0, 1, 1'b0, 0, 1'b0,
             2'd2, 1'b1, 1'b0, 1'b0, 3'd0);
    // halt_req wins over run=1 in WB
    do_instr("halt", NOTLOAD, NOTSTORE, NOTBRANCH, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0,
             2'd0, 1'b0, 1'b1, 1'b1, 3'd6);

    run = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_state", 32'(state), 32'd6);
      check("hold_ctl", 32'(ctl), 32'd1);
      check("hold_cyc", cycle_cnt, 32'(exp_cyc));
      check("hold_ret", instret_cnt, 32'(exp_ret));
    end

    // Reset in the middle of a stalled load
    rst = 1'b1; run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    tick();
    rst = 1'b0;
    info_load = LD_W; info_store = NOTSTORE; info_branch = NOTBRANCH; write_reg = 1'b1;
    run = 1'b1; imem_ready = 1'b1;
    tick();
    tick();
    imem_ready = 1'b0;
    tick();
    tick();
    check("rmem_state", 32'(state), 32'd4);
    check("rmem_dreq", 32'(dmem_req), 32'd1);
    check("rmem_cyc_pre", cycle_cnt, 32'd3);
    rst = 1'b1;
    #1;
    check("rmem_we_pre", 32'({reg_we, pc_we}), 32'd0);
    tick();
    rst = 1'b0; run = 1'b0;
    #1;
    check("rmem_state_post", 32'(state), 32'd0);
    check("rmem_dreq_post", 32'(dmem_req), 32'd0);
    check("rmem_cyc_post", cycle_cnt, 32'd0);
    check("rmem_ret_post", instret_cnt, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rmem_idle_ctl", 32'(ctl), 32'd0);
      check("rmem_idle_state", 32'(state), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle control FSM for the RV32I core.
- Sequences fetch, decode, execute, memory and writeback around the combinational decoder and ALU.
- Consumes the decoder's class outputs (info_load, info_store, info_branch, write_reg) and a branch-taken flag from the branch comparator.
- Drives instruction/data memory request handshakes, register-file and PC write enables, writeback source select, and retired-instruction/cycle counters.

Parameters:
- CNT_W, 32, width of cycle_cnt and instret_cnt

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- run  in  1  start/continue execution; sampled in IDLE and at WB exit
- halt_req  in  1  stop after the current instruction; sampled in WB
- imem_req  out  1  instruction fetch request
- imem_ready  in  1  fetch data valid this cycle
- ir_we  out  1  latch fetched word into the IR
- info_load  in  3  decoder load class (`NOTLOAD = not a load)
- info_store  in  2  decoder store class (`NOTSTORE = not a store)
- info_branch  in  3  decoder branch class (`NOTBRANCH, `BJAL, `BJALR, else conditional)
- write_reg  in  1  decoder: instruction writes rd
- br_taken  in  1  conditional-branch comparator result
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (store)
- dmem_ready  in  1  data access complete this cycle
- reg_we  out  1  register-file write enable
- wb_sel  out  2  writeback source: 0 = ALU, 1 = load data, 2 = PC+4
- pc_we  out  1  PC update enable
- pc_sel  out  1  0 = PC+4, 1 = target (ALU result)
- state  out  3  current state, for debug
- halted  out  1  FSM is in HALT
- cycle_cnt  out  CNT_W  active-cycle counter
- instret_cnt  out  CNT_W  retired-instruction counter

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Encodings 7 and above are unused and go to IDLE on the next edge.
- Reset: at a clk edge with rst=1, state=IDLE and both counters=0. All outputs are then 0.
  - rst dominates every other input.
  - Reset mid-FETCH or mid-MEM drops the request the cycle after the edge. The outstanding access is abandoned; no write enables are asserted.
- IDLE: all controls 0. run=1 goes to FETCH; otherwise stay.
- FETCH:
  - imem_req=1 until imem_ready.
  - ir_we = imem_ready (Mealy, same cycle).
  - On imem_ready go to DECODE; otherwise stay, holding imem_req.
- DECODE: exactly 1 cycle, no controls asserted. Go to EXEC.
- EXEC: exactly 1 cycle. Go to MEM if info_load != `NOTLOAD or info_store != `NOTSTORE; otherwise go to WB.
- MEM:
  - dmem_req=1 and dmem_we = (info_store != `NOTSTORE), held constant until dmem_ready.
  - On dmem_ready go to WB; otherwise stay.
- WB (exactly 1 cycle):
  - pc_we=1.
  - reg_we = write_reg. Stores and conditional branches have write_reg=0; x0 is handled in the register file.
  - wb_sel = 1 for loads, 2 for `BJAL/`BJALR, 0 otherwise.
  - pc_sel = 1 if info_branch is `BJAL or `BJALR, or if info_branch is conditional and br_taken=1; otherwise 0.
  - instret_cnt increments.
  - Next state, in priority order: halt_req → HALT; else run → FETCH; else IDLE.
- HALT: all controls 0 and halted=1. Exits only via rst.
- Input stability: decoder and br_taken inputs are stable from DECODE through WB, because the IR holds.
- run deassertion: run=0 mid-instruction does not abort. The instruction completes through WB, then the FSM goes to IDLE.
- cycle_cnt: increments on every edge where state is FETCH–WB. Wraps modulo 2^CNT_W.
- instret_cnt: wraps modulo 2^CNT_W.
- Latency with zero-wait memories:
  - ALU/branch/jump instructions: 4 cycles.
  - Loads/stores: 5 cycles.
  - Each extra wait cycle on imem_ready or dmem_ready adds 1 cycle.
- Mutual exclusion: imem_req and dmem_req are never both 1. ir_we, reg_we and pc_we are never asserted outside FETCH/WB.

Test Plan:
- ADD (write_reg=1, no load/store/branch), run=1, imem_ready=1 immediately → state sequence 1,2,3,5 then 1. In the WB cycle: reg_we=1, wb_sel=0, pc_we=1, pc_sel=0. instret_cnt=1, cycle_cnt=4.
- LW with dmem_ready asserted 3 cycles after MEM entry → dmem_req high 4 cycles with dmem_we=0, then WB with wb_sel=1 and reg_we=1. Total 8 cycles.
- SW → MEM with dmem_we=1, then WB with reg_we=0 and pc_we=1. imem_ready delayed 2 cycles → imem_req high 3 cycles; ir_we only in the last of them.
- BEQ with br_taken=1 then br_taken=0 → pc_sel=1 then 0, reg_we=0 both times. JAL and JALR → pc_sel=1, wb_sel=2, reg_we=1.
- halt_req=1 during WB → HALT, halted=1; counters frozen for 10 cycles despite run=1. run=0 during EXEC → instruction completes, then IDLE.
- rst=1 mid-MEM with dmem_ready=0 → next cycle state=0, dmem_req=0, counters=0, no reg_we/pc_we pulse.
